// File: rtl/ovf_counter_pkg.sv
// Shared constants for the overflow counter: active-low gfedcba hex glyphs,
// blank pattern and digit count for the 4-digit seven-segment display.
package ovf_counter_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the glyph for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_GLYPH[nib];
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Four-digit seven-segment scanner: free-running slot timer, digit rotation
// and hex decode of the selected nibble, all outputs registered.
module seg7_scan
  import ovf_counter_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [6:0]  displayer,
  output logic [3:0]  digit_selector
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [REF_W-1:0] r_refresh;
  logic [1:0]       r_idx;
  logic             w_slot_end;
  logic [1:0]       w_idx_next;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg_next;

  assign w_slot_end = (r_refresh == REF_W'(REFRESH_DIV - 1));
  assign w_idx_next = w_slot_end ? r_idx + 2'd1 : r_idx;
  assign w_nib      = value[4*w_idx_next +: 4];
  assign w_seg_next = (32'(w_idx_next) < NUM_DIGITS) ? hex_to_seg(w_nib) : SEG_BLANK;

  // Selector and glyph are registered from the same next index so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh      <= '0;
      r_idx          <= '0;
      digit_selector <= 4'b1110;
      displayer      <= SEG_GLYPH[0];
    end else begin
      r_refresh      <= w_slot_end ? '0 : r_refresh + REF_W'(1);
      r_idx          <= w_idx_next;
      digit_selector <= ~(4'b0001 << w_idx_next);
      displayer      <= w_seg_next;
    end
  end

endmodule

// File: rtl/param_overflow_counter.sv
// Prescaled up/down wrap counter with overflow strobe, sticky flag and
// multiplexed hex display. Define OVF_COUNTER_WRAPCNT_EN to add wrap_count.
module param_overflow_counter
  import ovf_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  output logic [CNT_W-1:0] led,
  output logic             overflow_pulse,
  output logic             overflow_sticky,
  output logic [6:0]       displayer,
  output logic [3:0]       digit_selector
`ifdef OVF_COUNTER_WRAPCNT_EN
  ,
  output logic [7:0]       wrap_count
`endif
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TICK_W-1:0] r_presc;
  logic              w_tick;
  logic              w_wrap;
  logic [15:0]       w_disp_value;

  assign w_tick       = enable && (r_presc == TICK_W'(TICK_DIV - 1));
  assign w_wrap       = w_tick && (up_down ? (led == CNT_MAX) : (led == '0));
  assign w_disp_value = 16'(led);

  // Clear outranks a coincident tick: no step, no strobe.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_presc         <= '0;
      led             <= '0;
      overflow_pulse  <= 1'b0;
      overflow_sticky <= 1'b0;
    end else if (clear) begin
      r_presc         <= '0;
      led             <= '0;
      overflow_pulse  <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      overflow_pulse <= w_wrap;
      if (enable) begin
        r_presc <= w_tick ? '0 : r_presc + TICK_W'(1);
      end
      if (w_tick) begin
        led <= up_down ? led + CNT_W'(1) : led - CNT_W'(1);
      end
      if (w_wrap) begin
        overflow_sticky <= 1'b1;
      end
    end
  end

`ifdef OVF_COUNTER_WRAPCNT_EN
  // Saturating count of wraps.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wrap_count <= '0;
    end else if (clear) begin
      wrap_count <= '0;
    end else if (w_wrap && (wrap_count != 8'hFF)) begin
      wrap_count <= wrap_count + 8'd1;
    end
  end
`endif

  seg7_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk           (clk_100MHz),
    .reset         (reset),
    .value         (w_disp_value),
    .displayer     (displayer),
    .digit_selector(digit_selector)
  );

endmodule

// File: tb/tb_param_overflow_counter.sv
// Bench for param_overflow_counter (CNT_W=4, TICK_DIV=4, REFRESH_DIV=3):
// arithmetic reference model checked every cycle plus directed literal checks.
module tb_param_overflow_counter;

  localparam int CNT_W       = 4;
  localparam int TICK_DIV    = 4;
  localparam int REFRESH_DIV = 3;
  localparam int MODV        = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             up_down = 1'b1;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] led;
  logic             overflow_pulse;
  logic             overflow_sticky;
  logic [6:0]       displayer;
  logic [3:0]       digit_selector;
`ifdef OVF_COUNTER_WRAPCNT_EN
  logic [7:0]       wrap_count;
`endif

  param_overflow_counter #(
    .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk_100MHz     (clk),
    .reset          (reset),
    .enable         (enable),
    .up_down        (up_down),
    .clear          (clear),
    .led            (led),
    .overflow_pulse (overflow_pulse),
    .overflow_sticky(overflow_sticky),
    .displayer      (displayer),
    .digit_selector (digit_selector)
`ifdef OVF_COUNTER_WRAPCNT_EN
    ,
    .wrap_count     (wrap_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  // Independent glyph table, index = hex digit value.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled cycles since clear decide ticks; integer count wraps modulo.
  int m_count, m_en, m_edges, m_shown, m_wraps;
  bit m_pulse, m_sticky;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0; m_en = 0; m_edges = 0; m_shown = 0; m_wraps = 0;
      m_pulse = 0; m_sticky = 0;
    end else begin
      int nxt;
      m_shown = m_count;
      m_edges++;
      if (clear) begin
        m_count = 0; m_en = 0; m_pulse = 0; m_sticky = 0; m_wraps = 0;
      end else begin
        m_pulse = 0;
        if (enable) begin
          m_en++;
          if (m_en % TICK_DIV == 0) begin
            nxt = m_count + (up_down ? 1 : -1);
            if (nxt < 0 || nxt >= MODV) begin
              m_pulse = 1; m_sticky = 1;
              if (m_wraps < 255) m_wraps++;
            end
            m_count = (nxt + MODV) % MODV;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_chk) begin
      int idx;
      idx = (m_edges / REFRESH_DIV) % 4;
      chk("model_led", 32'(led), 32'(m_count));
      chk("model_pulse", 32'(overflow_pulse), 32'(m_pulse));
      chk("model_sticky", 32'(overflow_sticky), 32'(m_sticky));
      chk("model_sel", 32'(digit_selector), 32'(4'hF & ~(4'b0001 << idx)));
      chk("model_seg", 32'(displayer), 32'(glyph[(m_shown >> (4 * idx)) & 15]));
`ifdef OVF_COUNTER_WRAPCNT_EN
      chk("model_wrapcnt", 32'(wrap_count), 32'(m_wraps));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [3:0] sel_exp [3] = '{4'b1101, 4'b1011, 4'b0111};

  initial begin
    bit found;
    #1 reset = 1'b1;
    step(1);
    run_chk = 1'b1;
    chk("rst_led", 32'(led), 0);
    chk("rst_pulse", 32'(overflow_pulse), 0);
    chk("rst_sticky", 32'(overflow_sticky), 0);
    chk("rst_sel", 32'(digit_selector), 32'h0E);
    chk("rst_seg", 32'(displayer), 32'h40);

    // Count up from reset and wrap 15 -> 0.
    step(1);
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    step(3);
    chk("up_pre_tick", 32'(led), 0);
    step(1);
    chk("up_first_tick", 32'(led), 1);
    step(60);
    chk("up_wrap_led", 32'(led), 0);
    chk("up_wrap_pulse", 32'(overflow_pulse), 1);
    chk("up_wrap_sticky", 32'(overflow_sticky), 1);
    step(1);
    chk("up_pulse_one_cycle", 32'(overflow_pulse), 0);

    // Clear, then count down from 0 to 15.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_sticky", 32'(overflow_sticky), 0);
    up_down = 1'b0;
    step(4);
    chk("dn_wrap_led", 32'(led), 15);
    chk("dn_wrap_pulse", 32'(overflow_pulse), 1);
    chk("dn_wrap_sticky", 32'(overflow_sticky), 1);

    // Hold with enable low at prescaler=2; up_down toggles are ignored.
    step(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up_down = ~up_down;
      step(1);
      chk("hold_led", 32'(led), 15);
    end
    up_down = 1'b0; enable = 1'b1;
    step(1);
    chk("resume_no_tick", 32'(led), 15);
    step(1);
    chk("resume_tick", 32'(led), 14);

    // Clear on the wrap cycle wins over the wrap.
    up_down = 1'b1;
    step(4);
    chk("pre_clr_led", 32'(led), 15);
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clrwrap_led", 32'(led), 0);
    chk("clrwrap_pulse", 32'(overflow_pulse), 0);
    chk("clrwrap_sticky", 32'(overflow_sticky), 0);

    // Display scan of 4'hA.
    step(40);
    enable = 1'b0;
    chk("disp_led", 32'(led), 10);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1);
      if (digit_selector == 4'b1110) found = 1'b1;
    end
    chk("disp_find_d0", 32'(found), 1);
    chk("disp_seg_d0", 32'(displayer), 32'h08);
    for (int d = 0; d < 3; d++) begin
      step(3);
      chk("disp_sel", 32'(digit_selector), 32'(sel_exp[d]));
      chk("disp_seg_hi", 32'(displayer), 32'h40);
    end

    // Asynchronous reset between edges.
    enable = 1'b1;
    step(6);
    #1 reset = 1'b1;
    #1;
    chk("arst_led", 32'(led), 0);
    chk("arst_pulse", 32'(overflow_pulse), 0);
    chk("arst_sticky", 32'(overflow_sticky), 0);
    chk("arst_sel", 32'(digit_selector), 32'h0E);
    chk("arst_seg", 32'(displayer), 32'h40);
    reset = 1'b0;
    step(8);
    chk("post_arst_led", 32'(led), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
